// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
// The forwarding selects are always present; they read as zero unless HAZARD_FORWARD_EN is built in.
interface pipeline_hazard_ctrl_if #(
    parameter int REGW = 4,
    parameter int CNTW = 16
);
    logic [REGW-1:0] id_rr1;
    logic [REGW-1:0] id_rr2;
    logic [REGW-1:0] id_rr3;
    logic            id_use1;
    logic            id_use2;
    logic            id_use3;
    logic [REGW-1:0] id_rd;
    logic            id_regwrite;
    logic            id_memread;
    logic            ex_jump_taken;
    logic            pc_write;
    logic            if_id_write;
    logic            if_id_flush;
    logic            id_ex_bubble;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [1:0]      fwd_c;
    logic [2:0]      id_byp;
    logic [1:0]      state;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output id_rr1, id_rr2, id_rr3, id_use1, id_use2, id_use3,
               id_rd, id_regwrite, id_memread, ex_jump_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               fwd_a, fwd_b, fwd_c, id_byp, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rr1, id_rr2, id_rr3, id_use1, id_use2, id_use3,
               id_rd, id_regwrite, id_memread, ex_jump_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               fwd_a, fwd_b, fwd_c, id_byp, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: 3-slot destination scoreboard (EX, MEM, WB), stall and jump-flush
// control, saturating perf counters. Define HAZARD_FORWARD_EN to add EX forwarding and ID bypass.
module pipeline_hazard_ctrl #(
    parameter int REGW = 4,
    parameter int CNTW = 16
) (
    input logic clk,
    input logic rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;

    state_t               state;
    logic                 ex_v, mem_v, wb_v;
    logic [REGW-1:0]      ex_rd, mem_rd, wb_rd;
    logic [2:0][REGW-1:0] src;
    logic [2:0]           src_use;
    logic [2:0]           hit_ex, hit_mem, hit_wb;
    logic                 hazard, jump, bubble;
    logic [CNTW-1:0]      stall_cnt, flush_cnt;
`ifdef HAZARD_FORWARD_EN
    logic                 ex_ld, mem_ld;
    logic [2:0][REGW-1:0] ex_src;
    logic [2:0]           ex_use;
    logic [2:0][1:0]      fwd;
`endif

    assign src     = {hz.id_rr3, hz.id_rr2, hz.id_rr1};
    assign src_use = {hz.id_use3, hz.id_use2, hz.id_use1};

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            hit_ex[j]  = src_use[j] && ex_v  && (ex_rd  == src[j]);
            hit_mem[j] = src_use[j] && mem_v && (mem_rd == src[j]);
            hit_wb[j]  = src_use[j] && wb_v  && (wb_rd  == src[j]);
        end
    end

`ifdef HAZARD_FORWARD_EN
    // Only a load still in EX or MEM has no value to forward yet.
    assign hazard = (ex_ld && (|hit_ex)) || (mem_ld && (|hit_mem));

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            fwd[j] = 2'b00;
            if (ex_use[j] && mem_v && !mem_ld && (mem_rd == ex_src[j]))
                fwd[j] = 2'b01;
            else if (ex_use[j] && wb_v && (wb_rd == ex_src[j]))
                fwd[j] = 2'b10;
        end
    end

    assign hz.fwd_a  = fwd[0];
    assign hz.fwd_b  = fwd[1];
    assign hz.fwd_c  = fwd[2];
    assign hz.id_byp = hit_wb;
`else
    // The register file writes at the edge, so a WB-slot producer is still unreadable from ID.
    assign hazard = |{hit_ex, hit_mem, hit_wb};

    assign hz.fwd_a  = 2'b00;
    assign hz.fwd_b  = 2'b00;
    assign hz.fwd_c  = 2'b00;
    assign hz.id_byp = 3'b000;
`endif

    // EX holds a bubble during FLUSH, so a jump request seen then is stale and ignored.
    assign jump   = hz.ex_jump_taken && (state != FLUSH);
    assign bubble = jump || hazard;

    // Flow control: pc_write / if_id_write are the "ready" back to fetch; the ID instruction is
    // accepted at an edge only when if_id_write=1 and if_id_flush=0, otherwise it is held or killed.
    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        if (rst) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
        end else if (jump) begin
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
        end else if (hazard) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ex_v      <= 1'b0;
            mem_v     <= 1'b0;
            wb_v      <= 1'b0;
            ex_rd     <= '0;
            mem_rd    <= '0;
            wb_rd     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
`ifdef HAZARD_FORWARD_EN
            ex_ld     <= 1'b0;
            mem_ld    <= 1'b0;
            ex_src    <= '0;
            ex_use    <= 3'b000;
`endif
        end else begin
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            ex_v   <= hz.id_regwrite && !bubble;
            ex_rd  <= hz.id_rd;
`ifdef HAZARD_FORWARD_EN
            mem_ld <= ex_ld;
            ex_ld  <= hz.id_memread;
            ex_src <= src;
            ex_use <= bubble ? 3'b000 : src_use;
`endif
            if (jump)
                state <= FLUSH;
            else if (hazard)
                state <= STALL;
            else
                state <= RUN;

            if (jump) begin
                if (flush_cnt != '1)
                    flush_cnt <= flush_cnt + CNTW'(1);
            end else if (hazard) begin
                if (stall_cnt != '1)
                    stall_cnt <= stall_cnt + CNTW'(1);
            end
        end
    end

    assign hz.state     = state;
    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed instruction sequences checked against an in-bench
// in-flight-instruction model every cycle, plus literal expectations for the key scenarios.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   tests;
    int   fails;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REGW(4), .CNTW(16)) bus ();
    pipeline_hazard_ctrl_if #(.REGW(4), .CNTW(2))  sat_bus ();

    pipeline_hazard_ctrl #(.REGW(4), .CNTW(16)) dut (.clk(clk), .rst(rst), .hz(bus));
    pipeline_hazard_ctrl #(.REGW(4), .CNTW(2))  dut_sat (.clk(clk), .rst(rst), .hz(sat_bus));

    assign sat_bus.id_rr1        = bus.id_rr1;
    assign sat_bus.id_rr2        = bus.id_rr2;
    assign sat_bus.id_rr3        = bus.id_rr3;
    assign sat_bus.id_use1       = bus.id_use1;
    assign sat_bus.id_use2       = bus.id_use2;
    assign sat_bus.id_use3       = bus.id_use3;
    assign sat_bus.id_rd         = bus.id_rd;
    assign sat_bus.id_regwrite   = bus.id_regwrite;
    assign sat_bus.id_memread    = bus.id_memread;
    assign sat_bus.ex_jump_taken = bus.ex_jump_taken;

    // ---------------- model: youngest in-flight instruction at index 0 (EX), then MEM, WB
    typedef struct packed {
        logic            v;
        logic [3:0]      rd;
        logic            ld;
        logic [2:0][3:0] s;
        logic [2:0]      u;
    } slot_t;

    slot_t           sb_q[$];
    slot_t           ent;
    int              m_state;
    int              m_stall;
    int              m_flush;
    logic            m_jump, m_hz, e_bub;
    logic [2:0]      m_byp;
    logic [1:0]      m_fw[3];
    logic [2:0][3:0] m_rr;
    logic [2:0]      m_use;
    logic            exp_hold;
    logic [2:0]      issue_byp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb_q = {};
            for (int i = 0; i < 3; i++) sb_q.push_back('0);
            m_state  = 0;
            m_stall  = 0;
            m_flush  = 0;
            exp_hold = 1'b0;
            check("rst_pc_write", bus.pc_write, 0);
            check("rst_if_id_write", bus.if_id_write, 0);
            check("rst_if_id_flush", bus.if_id_flush, 1);
            check("rst_id_ex_bubble", bus.id_ex_bubble, 1);
            check("rst_fwd_a", bus.fwd_a, 0);
            check("rst_fwd_b", bus.fwd_b, 0);
            check("rst_fwd_c", bus.fwd_c, 0);
            check("rst_id_byp", bus.id_byp, 0);
            check("rst_state", bus.state, 0);
            check("rst_stall_cnt", bus.stall_cnt, 0);
            check("rst_flush_cnt", bus.flush_cnt, 0);
            check("rst_sat_stall_cnt", sat_bus.stall_cnt, 0);
        end else begin
            m_rr   = {bus.id_rr3, bus.id_rr2, bus.id_rr1};
            m_use  = {bus.id_use3, bus.id_use2, bus.id_use1};
            m_jump = bus.ex_jump_taken && (m_state != 2);
            m_hz   = 1'b0;
            m_byp  = 3'b000;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    if (m_use[j] && sb_q[i].v && (sb_q[i].rd == m_rr[j])) begin
`ifdef HAZARD_FORWARD_EN
                        if (i < 2 && sb_q[i].ld) m_hz = 1'b1;
                        if (i == 2) m_byp[j] = 1'b1;
`else
                        m_hz = 1'b1;
`endif
                    end
            for (int j = 0; j < 3; j++) begin
                m_fw[j] = 2'b00;
`ifdef HAZARD_FORWARD_EN
                if (sb_q[0].u[j]) begin
                    if (sb_q[1].v && !sb_q[1].ld && (sb_q[1].rd == sb_q[0].s[j])) m_fw[j] = 2'b01;
                    else if (sb_q[2].v && (sb_q[2].rd == sb_q[0].s[j])) m_fw[j] = 2'b10;
                end
`endif
            end
            e_bub = m_jump || m_hz;
            check("pc_write", bus.pc_write, m_jump || !m_hz);
            check("if_id_write", bus.if_id_write, m_jump || !m_hz);
            check("if_id_flush", bus.if_id_flush, m_jump);
            check("id_ex_bubble", bus.id_ex_bubble, e_bub);
            check("fwd_a", bus.fwd_a, m_fw[0]);
            check("fwd_b", bus.fwd_b, m_fw[1]);
            check("fwd_c", bus.fwd_c, m_fw[2]);
            check("id_byp", bus.id_byp, m_byp);
            check("state", bus.state, m_state);
            check("stall_cnt", bus.stall_cnt, m_stall);
            check("flush_cnt", bus.flush_cnt, m_flush);
            check("sat_stall_cnt", sat_bus.stall_cnt, sat3(m_stall));
            check("sat_flush_cnt", sat_bus.flush_cnt, sat3(m_flush));
            // advance the model across the coming edge
            if (m_jump) m_flush++;
            else if (m_hz) m_stall++;
            m_state  = m_jump ? 2 : (m_hz ? 1 : 0);
            ent.v    = bus.id_regwrite && !e_bub;
            ent.rd   = bus.id_rd;
            ent.ld   = bus.id_memread;
            ent.s    = m_rr;
            ent.u    = e_bub ? 3'b000 : m_use;
            sb_q.push_front(ent);
            void'(sb_q.pop_back());
            exp_hold = m_hz && !m_jump;
        end
    end

    // ---------------- driver tasks
    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [3:0] rd, input logic rw, input logic ld,
                          input logic [3:0] r1, input logic u1, input logic [3:0] r2, input logic u2,
                          input logic [3:0] r3, input logic u3);
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = ld;
        bus.id_rr1      = r1;
        bus.id_use1     = u1;
        bus.id_rr2      = r2;
        bus.id_use2     = u2;
        bus.id_rr3      = r3;
        bus.id_use3     = u3;
    endtask

    // Presents one instruction in ID and holds it until the model says it is accepted.
    task automatic issue(input logic [3:0] rd, input logic rw, input logic ld,
                         input logic [3:0] r1, input logic u1, input logic [3:0] r2, input logic u2,
                         input logic [3:0] r3, input logic u3, output int stalls);
        set_id(rd, rw, ld, r1, u1, r2, u2, r3, u3);
        bus.ex_jump_taken = 1'b0;
        stalls = 0;
        settle();
        while (exp_hold && stalls < 8) begin
            stalls++;
            advance();
            settle();
        end
        if (exp_hold) begin
            tests++;
            fails++;
            $display("FAIL issue_bound: still held after %0d cycles, expected release", stalls);
        end
        issue_byp = bus.id_byp;
        advance();
    endtask

    task automatic nop();
        int n;
        issue(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        set_id(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        bus.ex_jump_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        advance();
        settle();
        check("first_edge_pc_write", bus.pc_write, 1);
        check("first_edge_if_id_write", bus.if_id_write, 1);
        check("first_edge_if_id_flush", bus.if_id_flush, 0);
        check("first_edge_bubble", bus.id_ex_bubble, 0);
        check("first_edge_state", bus.state, 0);
        advance();

        // reset in the middle of a load-use stall
        issue(4'd6, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        set_id(4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        settle();
        check("mid_stall_pc_write", bus.pc_write, 0);
        advance();
        rst = 1'b1;
        settle();
        check("rst_mid_stall_pc_write", bus.pc_write, 0);
        check("rst_mid_stall_flush", bus.if_id_flush, 1);
        check("rst_mid_stall_state", bus.state, 0);
        check("rst_mid_stall_cnt", bus.stall_cnt, 0);
        repeat (2) begin advance(); settle(); end
        advance();
        rst = 1'b0;
        settle();
        check("post_rst_no_stall", bus.pc_write, 1);
        advance();
        check("post_rst_state", bus.state, 0);
        nop();

`ifdef HAZARD_FORWARD_EN
        issue(4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        issue(4'd1, 1'b0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, n);
        check("fwd_dist1_stalls", n, 0);
        check("fwd_dist1_fwd_a", bus.fwd_a, 2'b01);
        issue(4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        nop();
        issue(4'd1, 1'b0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, n);
        check("fwd_dist2_fwd_a", bus.fwd_a, 2'b10);
        issue(4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        nop();
        nop();
        issue(4'd1, 1'b0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, n);
        check("fwd_dist3_stalls", n, 0);
        check("fwd_dist3_id_byp", issue_byp, 3'b001);
        issue(4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        issue(4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0, n);
        check("fwd_dist1_fwd_b", bus.fwd_b, 2'b01);
        issue(4'd10, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        nop();
        issue(4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, n);
        check("fwd_dist2_fwd_c", bus.fwd_c, 2'b10);
        issue(4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        issue(4'd1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, n);
        check("fwd_r0_stalls", n, 0);
        check("fwd_r0_fwd_a", bus.fwd_a, 2'b01);
        issue(4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        issue(4'd1, 1'b0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, n);
        check("load_use_stalls", n, 2);
        check("load_use_id_byp", issue_byp, 3'b001);
        check("load_use_stall_cnt", bus.stall_cnt, 2);
`else
        issue(4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        issue(4'd1, 1'b0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, n);
        check("raw_dist1_stalls", n, 3);
        check("raw_dist1_stall_cnt", bus.stall_cnt, 3);
        issue(4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        nop();
        issue(4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0, n);
        check("raw_dist2_rr2_stalls", n, 2);
        issue(4'd10, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        nop();
        nop();
        issue(4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, n);
        check("raw_dist3_rr3_stalls", n, 1);
        issue(4'd11, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        nop();
        nop();
        nop();
        issue(4'd1, 1'b0, 1'b0, 4'd11, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, n);
        check("raw_dist4_stalls", n, 0);
        issue(4'd12, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        issue(4'd1, 1'b0, 1'b0, 4'd12, 1'b0, 4'd12, 1'b0, 4'd12, 1'b0, n);
        check("unused_src_stalls", n, 0);
        issue(4'd4, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        issue(4'd1, 1'b0, 1'b0, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, n);
        check("no_regwrite_stalls", n, 0);
        issue(4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        issue(4'd1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, n);
        check("r0_dist1_stalls", n, 3);
        issue(4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        issue(4'd1, 1'b0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, n);
        check("load_use_nofwd_stalls", n, 3);
        check("load_use_nofwd_stall_cnt", bus.stall_cnt, 12);
`endif

        // taken jump while ID is stalled on R3
        issue(4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        set_id(4'd1, 1'b0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        settle();
        check("jump_pre_stall_pc_write", bus.pc_write, 0);
        advance();
        bus.ex_jump_taken = 1'b1;
        settle();
        check("jump_if_id_flush", bus.if_id_flush, 1);
        check("jump_id_ex_bubble", bus.id_ex_bubble, 1);
        check("jump_pc_write", bus.pc_write, 1);
        check("jump_state_stall", bus.state, 1);
        advance();
        set_id(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        settle();
        check("flush_state", bus.state, 2);
        check("flush_ignores_jump", bus.if_id_flush, 0);
        check("flush_cnt_one", bus.flush_cnt, 1);
`ifdef HAZARD_FORWARD_EN
        check("flush_stall_cnt_kept", bus.stall_cnt, 3);
`else
        check("flush_stall_cnt_kept", bus.stall_cnt, 13);
`endif
        advance();
        bus.ex_jump_taken = 1'b0;
        settle();
        check("after_flush_state", bus.state, 0);
        advance();

        // one more hazard: the narrow-counter instance must stay pinned at all-ones
        issue(4'd8, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, n);
        issue(4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 4'd0, 1'b0, n);
`ifdef HAZARD_FORWARD_EN
        check("final_stall_cnt", bus.stall_cnt, 5);
`else
        check("final_stall_cnt", bus.stall_cnt, 16);
`endif
        check("sat_stall_cnt_held", sat_bus.stall_cnt, 2'b11);
        check("sat_flush_cnt", sat_bus.flush_cnt, 2'b01);
        nop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It keeps a private 3-entry scoreboard of in-flight destination registers and compares them against the source registers of the instruction in ID. From that comparison it drives the PC enable, the IF/ID write-enable/flush and the ID/EX bubble insertion, and squashes wrong-path instructions on a taken jump. With forwarding compiled in, it also drives the EX operand-forwarding selects and the ID write-back bypass selects.

## Interface
Parameters:
- REGW, 4, register-index width (16 registers; index 0 is an ordinary register)
- CNTW, 16, width of the performance counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rr1, id_rr2, id_rr3  in  REGW  source indices of the ID instruction (RR1, RR2, RR3 read port)
- id_use1, id_use2, id_use3  in  1  source actually read (id_use3 only for stores)
- id_rd  in  REGW  destination index of the ID instruction
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- ex_jump_taken  in  1  taken jump resolved in EX (PCSource)
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID clears to NOP at the next edge
- id_ex_bubble  out  1  ID/EX control fields cleared at the next edge
- fwd_a, fwd_b, fwd_c  out  2  EX operand select: 00 register, 01 alu_res_mem, 10 result_wb
- id_byp  out  3  per-source ID select of result_wb
- state  out  2  00 RUN, 01 STALL, 10 FLUSH
- stall_cnt, flush_cnt  out  CNTW  saturating counts of stall cycles and flush events

## Operation
- Scoreboard slots EX, MEM, WB each hold {valid, rd, load}. They shift every clock: WB←MEM, MEM←EX, EX←{id_regwrite, id_rd, id_memread}.
- The new EX entry is invalid when id_ex_bubble=1.
- A source matches when its id_use* bit is set, the slot is valid and rd equals the source index.
- hazard without forwarding: any match against the EX, MEM or WB slot. The WB slot counts because the register file writes at the edge and ID reads the old value.
- Response to hazard: pc_write=0, if_id_write=0, id_ex_bubble=1, stall_cnt+1.
- Jump: ex_jump_taken=1 gives if_id_flush=1 and id_ex_bubble=1, with pc_write=1 so the PC loads the target. flush_cnt+1.
- The jump has priority over a hazard: the stalled instruction is younger and is discarded.
- FSM:
  - RUN→STALL on hazard; STALL→RUN when the hazard clears.
  - RUN/STALL→FLUSH on a jump. FLUSH lasts exactly one cycle, during which ex_jump_taken is ignored (EX holds a bubble), then →RUN or →STALL.
- Counters saturate at all-ones and do not wrap.

## Timing
- All control outputs are combinational from the scoreboard, the ID inputs and state. Scoreboard, state and counters are registered.
- Without forwarding, a consumer directly behind a producer stalls 3 cycles.
- While rst=1: scoreboard invalid, state=RUN, counters=0, pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, fwd_*=00, id_byp=000.
- After the first rising edge following rst deassertion: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- Reset asserted mid-stall or mid-flush clears everything immediately. No pending stall survives reset.

## Configuration
- HAZARD_FORWARD_EN defined:
  - The controller registers the ID sources alongside the EX slot.
  - fwd_* selects MEM (non-load) over WB.
  - id_byp is set for ID sources matching the WB slot.
  - Stalls occur only when a load in the EX or MEM slot matches, giving 2 cycles for load-use. A non-load producer causes no stall.
- Macro undefined:
  - fwd_* and id_byp are constant 0.
  - Stall on any match, as described under Operation.

## Test plan
- Reset held 3 cycles, mid-stall → all outputs at reset values. First edge after release → pc_write=1, state=RUN.
- Without forwarding, ADD writes R5, next instruction reads R5 → 3 stall cycles, stall_cnt=3, then the consumer issues.
- With HAZARD_FORWARD_EN, ADD R5 then SUB reading R5 → no stall, fwd_a=01 in the consumer's EX cycle. The same case at distance 2 → fwd_a=10. At distance 3 → id_byp[0]=1.
- With HAZARD_FORWARD_EN, load R7 followed by a use of R7 → 2 stall cycles, then id_byp set. stall_cnt=2.
- ex_jump_taken=1 while ID is stalled on R3 → if_id_flush=1, id_ex_bubble=1, pc_write=1. state=FLUSH for 1 cycle. flush_cnt=1, stall_cnt unchanged.
- Force stall_cnt to 0xFFFF and create another hazard → stall_cnt stays 0xFFFF.
